// File: rtl/prog_sequencer.sv
// Program sequencer: req/done run handshake, relative/absolute jumps, call/return stack.
// Optional PROG_SEQUENCER_CYCLE_CNT_EN adds a saturating 16-bit RUN-cycle counter output.
module prog_sequencer #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 128,
  parameter int SD         = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         stall,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stack_err
`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
  ,
  output logic [15:0]  cycle_cnt
`endif
);

  localparam int SPW = $clog2(SD + 1);
  localparam int AW  = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [D-1:0]   START_PC = D'(START_ADDR);
  localparam logic [D-1:0]   END_PC   = D'(END_ADDR);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(SD);
  // An END_ADDR outside the PC range can never match.
  localparam bit END_OK = (longint'(END_ADDR) < (longint'(1) << D));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           push_en;
  logic [AW-1:0]  push_idx, pop_idx;
  logic [D-1:0]   pc_inc;
  logic           at_end;
  logic [D-1:0]   stack_q [SD];

  assign pc_inc   = pc_q + 1'b1;
  assign at_end   = END_OK && (pc_q == END_PC);
  assign push_idx = AW'(sp_q);
  assign pop_idx  = AW'(sp_q - 1'b1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = RUN;
          pc_d    = START_PC;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (at_end) begin
          state_d = DONE;
        end else if (!stall) begin
          if (ret_en) begin
            if (sp_q == '0) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              pc_d = stack_q[pop_idx];
              sp_d = sp_q - 1'b1;
            end
          end else if (call_en) begin
            if (sp_q == SP_FULL) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
              pc_d    = target;
            end
          end else if (absjump_en) begin
            pc_d = target;
          end else if (reljump_en) begin
            pc_d = pc_q + target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      sp_q      <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Stack storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign prog_ctr  = pc_q;
  assign running   = running_q;
  assign done      = done_q;
  assign stack_err = err_q;

`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != RUN && state_d == RUN) cnt_d = '0;
    else if (state_q == RUN && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed scenarios plus random strobes, checked every cycle
// against a queue-based behavioural model of the sequencer.
module tb_prog_sequencer;
  localparam int D = 12, START_ADDR = 0, END_ADDR = 128, SD = 4;

  logic         clk = 1'b0;
  logic         reset, req, stall, reljump_en, absjump_en, call_en, ret_en;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         running, done, stack_err;
`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
  logic [15:0]  cycle_cnt;
`endif

  int tests = 0, fails = 0;

  // Model state: 0 idle, 1 run, 2 done
  int m_st = 0, m_pc = 0, m_cnt = 0;
  bit m_err = 1'b0;
  int m_stk[$];

  prog_sequencer #(.D(D), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR), .SD(SD)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .prog_ctr(prog_ctr), .running(running), .done(done), .stack_err(stack_err)
`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    reset = 0; req = 0; stall = 0; reljump_en = 0; absjump_en = 0;
    call_en = 0; ret_en = 0; target = '0;
  endtask

  task automatic model_start();
    m_st = 1; m_pc = START_ADDR; m_stk.delete(); m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int pc0;
    if (reset) begin
      m_st = 0; m_pc = 0; m_stk.delete(); m_err = 0; m_cnt = 0;
    end else if (m_st != 1) begin
      if (req) model_start();
    end else begin
      pc0 = m_pc;
      if (m_cnt < 65535) m_cnt++;
      if (pc0 == END_ADDR) m_st = 2;
      else if (stall) ;
      else if (ret_en) begin
        if (m_stk.size() == 0) begin m_err = 1; m_st = 2; end
        else m_pc = m_stk.pop_back();
      end else if (call_en) begin
        if (m_stk.size() == SD) begin m_err = 1; m_st = 2; end
        else begin m_stk.push_back((pc0 + 1) % (1 << D)); m_pc = target; end
      end else if (absjump_en) m_pc = target;
      else if (reljump_en) m_pc = (pc0 + target) % (1 << D);
      else m_pc = (pc0 + 1) % (1 << D);
    end
  endtask

  // One clock: model follows the inputs sampled at the edge, DUT checked #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("prog_ctr", prog_ctr, m_pc);
    chk("running", running, m_st == 1);
    chk("done", done, m_st == 2);
    chk("stack_err", stack_err, m_err);
`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, m_cnt);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clr();
    reset = 1;
    steps(2);
    chk("reset_pc", prog_ctr, 0);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    chk("reset_err", stack_err, 0);
    clr();
    step();

    // Full run 0..128 with no strobes
    req = 1; step(); req = 0;
    chk("start_pc", prog_ctr, START_ADDR);
    chk("start_running", running, 1);
    for (int i = 0; i < 200 && !done; i++) step();
    chk("end_pc", prog_ctr, 128);
    chk("end_done", done, 1);
    chk("end_running", running, 0);
    steps(3);
    chk("end_hold_pc", prog_ctr, 128);

    // Relative jump backwards and PC wrap
    req = 1; step(); req = 0;
    steps(5);
    chk("pc5", prog_ctr, 5);
    reljump_en = 1; target = 12'hFFD; step(); clr();
    chk("reljump_neg", prog_ctr, 2);
    absjump_en = 1; target = 12'hFFF; step(); clr();
    chk("abs_4095", prog_ctr, 4095);
    step();
    chk("wrap", prog_ctr, 0);

    // Call / return, nesting to SD, overflow
    absjump_en = 1; target = 10; step(); clr();
    call_en = 1; target = 40; step(); clr();
    chk("call_pc", prog_ctr, 40);
    steps(2);
    ret_en = 1; step(); clr();
    chk("ret_pc", prog_ctr, 11);
    call_en = 1;
    target = 20; step();
    target = 30; step();
    target = 50; step();
    target = 60; step();
    chk("nest4_pc", prog_ctr, 60);
    chk("nest4_running", running, 1);
    target = 70; step(); clr();
    chk("ovf_pc", prog_ctr, 60);
    chk("ovf_err", stack_err, 1);
    chk("ovf_done", done, 1);

    // Underflow, then restart clears the flag
    req = 1; step(); req = 0;
    chk("restart_err", stack_err, 0);
    chk("restart_done", done, 0);
    ret_en = 1; step(); clr();
    chk("unf_err", stack_err, 1);
    chk("unf_done", done, 1);
    req = 1; step(); req = 0;
    chk("restart2_pc", prog_ctr, START_ADDR);
    chk("restart2_err", stack_err, 0);

    // Stall beats call; a later ret proves sp stayed at zero
    steps(7);
    chk("pc7", prog_ctr, 7);
    stall = 1; call_en = 1; target = 99; step(); clr();
    chk("stall_pc", prog_ctr, 7);
    ret_en = 1; step(); clr();
    chk("stall_sp_err", stack_err, 1);

    // Mid-run reset
    req = 1; step(); req = 0;
    steps(60);
    chk("pc60", prog_ctr, 60);
    reset = 1; step(); clr();
    chk("mid_reset_pc", prog_ctr, 0);
    chk("mid_reset_running", running, 0);
    steps(2);
    chk("idle_hold_pc", prog_ctr, 0);

`ifdef PROG_SEQUENCER_CYCLE_CNT_EN
    // 20 RUN cycles: jump, 3 stalls, 15 increments, END cycle
    req = 1; step(); req = 0;
    absjump_en = 1; target = 113; step(); clr();
    stall = 1; steps(3); clr();
    steps(16);
    chk("cnt_20", cycle_cnt, 20);
    chk("cnt_done", done, 1);
    steps(3);
    chk("cnt_held", cycle_cnt, 20);
    req = 1; step(); req = 0;
    chk("cnt_cleared", cycle_cnt, 0);
`endif

    // Random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      clr();
      reset      = ($urandom_range(0, 199) == 0);
      req        = ($urandom_range(0, 7) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      reljump_en = ($urandom_range(0, 9) == 0);
      absjump_en = ($urandom_range(0, 9) == 0);
      call_en    = ($urandom_range(0, 7) == 0);
      ret_en     = ($urandom_range(0, 7) == 0);
      target     = $urandom_range(0, 1) ? D'($urandom_range(110, 135)) : D'($urandom);
      step();
    end
    clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
